// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch front end. This is the producer side of the IF/ID
//   pipeline register. It owns the program counter and runs a req/ready
//   handshake with a variable-latency instruction memory. Each cycle it
//   presents {PC+STEP, Instruction, valid} to the IF stage register. It
//   honours downstream freeze and EXE branch redirects, and it drives a NOP
//   bubble whenever no real instruction is available.
//
// Ports
//   clk           in   1   single clock, all state changes on posedge
//   rst           in   1   synchronous, active-high reset
//   freeze        in   1   downstream stall; hold the current instruction
//   branch_taken  in   1   one-cycle redirect pulse from EXE
//   branch_addr   in   32  redirect target, used when branch_taken=1
//   imem_req      out  1   memory request, held until imem_ready
//   imem_addr     out  32  fetch address, stable while a request is open
//   imem_ready    in   1   one-cycle pulse: imem_rdata is valid
//   imem_rdata    in   32  instruction word
//   PC            out  32  address of the delivered instruction + PC_STEP
//   Instruction   out  32  delivered instruction, or NOP_INSTR if !valid
//   valid         out  1   PC/Instruction carry a real instruction
//   mem_wait      out  1   waiting on memory in FETCH (miss indicator)
// ----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        valid,
  output logic        mem_wait
);

  // FETCH: request open at r_pc. HOLD: the word is parked while downstream
  // is frozen. FLUSH: a redirect arrived mid-access, so the stale access
  // finishes before the unit moves to the saved target.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  logic [31:0] r_hold;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_tgt_nxt;
  logic [31:0] w_hold_nxt;
  logic [31:0] w_pc_inc;
  logic [31:0] w_instr;
  logic        w_valid;
  logic        w_req;

  // Modulo 2^32 addition. The top address wraps to zero by design.
  assign w_pc_inc = r_pc + PC_STEP;

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register samples the same pre-edge values, and this holds regardless
  // of the order of the statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // NOTE: every signal written here gets a default value first. Any path
  // that skips an assignment then keeps the default, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    w_hold_nxt  = r_hold;
    w_valid     = 1'b0;
    w_instr     = r_hold;
    w_req       = 1'b0;

    unique case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (imem_ready) begin
          if (branch_taken) begin
            // The word belongs to the wrong path. Drop it and refetch.
            w_pc_nxt = branch_addr;
          end else if (!freeze) begin
            w_valid  = 1'b1;
            w_instr  = imem_rdata;
            w_pc_nxt = w_pc_inc;
          end else begin
            // Downstream is stalled. Park the word until it can be taken.
            w_hold_nxt  = imem_rdata;
            w_state_nxt = S_HOLD;
          end
        end else if (branch_taken) begin
          // The address must stay stable, so only remember the target.
          w_tgt_nxt   = branch_addr;
          w_state_nxt = S_FLUSH;
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          w_pc_nxt    = branch_addr;
          w_state_nxt = S_FETCH;
        end else begin
          w_valid = 1'b1;
          w_instr = r_hold;
          if (!freeze) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
          end
        end
      end

      S_FLUSH: begin
        w_req = 1'b1;
        // The latest redirect wins, including one in the same cycle as ready.
        if (branch_taken) begin
          w_tgt_nxt = branch_addr;
        end
        if (imem_ready) begin
          w_pc_nxt    = branch_taken ? branch_addr : r_tgt;
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // While rst is high the outputs show the idle reset view, whatever the
  // current (possibly uninitialised) state is.
  assign imem_req    = w_req & ~rst;
  assign imem_addr   = r_pc;
  assign valid       = w_valid & ~rst;
  assign Instruction = valid ? w_instr : NOP_INSTR;
  assign PC          = rst ? (RESET_PC + PC_STEP) : w_pc_inc;
  assign mem_wait    = ~rst & (r_state == S_FETCH) & ~imem_ready;

endmodule
